vxe_txnreqd_decoder: RTL

//  Receive side of the request-data channel. Accepts 72-bit request data vectors {ben[7:0], data[63:0]},

---
 rtl/vxe_txnreqd_decoder_pkg.sv | 22 ++
 rtl/vxe_txnreqd_fifo.sv | 75 +++++++
 rtl/vxe_txnreqd_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/vxe_txnreqd_decoder_pkg.sv
// Shared definitions for the request-data receive path: vector field positions,
// FSM state encoding and the layout of one buffered beat.
package vxe_txnreqd_decoder_pkg;

    localparam int REQD_VEC_W   = 72;
    localparam int REQD_DAT_LSB = 0;
    localparam int REQD_DAT_MSB = 63;
    localparam int REQD_BEN_LSB = 64;
    localparam int REQD_BEN_MSB = 71;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } reqd_state_e;

    typedef struct packed {
        logic        last;
        logic [7:0]  ben;
        logic [63:0] data;
    } reqd_entry_t;

endpackage

// File: rtl/vxe_txnreqd_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is read
// combinationally so a pushed word is visible the cycle after the push edge.
module vxe_txnreqd_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // No pass-through when full: a push is refused even if a pop frees a slot this cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vxe_txnreqd_decoder.sv
// Request-data channel receiver: splits incoming vectors into data and byte
// enables, tags the final beat of each burst and buffers beats for the write sink.
module vxe_txnreqd_decoder
    import vxe_txnreqd_decoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_W-1:0]      i_len,
    input  logic                  i_len_vld,
    output logic                  o_len_rdy,
    input  logic [REQD_VEC_W-1:0] i_req_vec_dat,
    input  logic                  i_vld,
    output logic                  o_rdy,
    output logic [63:0]           o_data,
    output logic [7:0]            o_ben,
    output logic                  o_last,
    output logic                  o_vld,
    input  logic                  i_rd,
    output logic                  o_zben,
    output logic                  o_busy
);

    reqd_state_e       state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              zben_q, zben_d;

    reqd_entry_t       push_entry;
    reqd_entry_t       head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic              push;

    assign push_entry.last = (cnt_q == '0);
    assign push_entry.ben  = i_req_vec_dat[REQD_BEN_MSB:REQD_BEN_LSB];
    assign push_entry.data = i_req_vec_dat[REQD_DAT_MSB:REQD_DAT_LSB];

    assign push = i_vld & o_rdy;

    vxe_txnreqd_fifo #(
        .DATA_W ($bits(reqd_entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (i_rd),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        zben_d    = zben_q;
        o_len_rdy = 1'b0;
        o_rdy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_len_rdy = 1'b1;
                if (i_len_vld) begin
                    cnt_d   = i_len;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                o_rdy = ~fifo_full;
                // The push of the final beat leaves BURST; the next length waits a cycle in IDLE.
                if (i_vld && !fifo_full) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (push_entry.ben == 8'h00) begin
                        zben_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            zben_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zben_q  <= zben_d;
        end
    end

    assign o_vld  = ~fifo_empty;
    assign o_data = o_vld ? head_entry.data : '0;
    assign o_ben  = o_vld ? head_entry.ben  : '0;
    assign o_last = o_vld ? head_entry.last : 1'b0;
    assign o_zben = zben_q;
    assign o_busy = (state_q == ST_BURST) | (fifo_count != '0);

endmodule
